// File: rtl/relation_detector_pipe.sv
// rtl/relation_detector_pipe.sv - two-stage A/B relation classifier with event counters and gray-streak FSM
module relation_detector_pipe #(
    parameter int W          = 3,
    parameter int DIST       = 3,
    parameter int CNT_W      = 8,
    parameter int STREAK_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [W-1:0]             a,
    input  logic [W-1:0]             b,
    input  logic                     clr_cnt,
    output logic                     out_valid,
    output logic                     gray,
    output logic                     dist_k,
    output logic                     more,
    output logic                     less,
    output logic                     no_relation,
    output logic [$clog2(W+1)-1:0]   hamming,
    output logic [CNT_W-1:0]         cnt_gray,
    output logic [CNT_W-1:0]         cnt_dist,
    output logic [CNT_W-1:0]         cnt_more,
    output logic [CNT_W-1:0]         cnt_less,
    output logic [CNT_W-1:0]         cnt_none,
    output logic [CNT_W-1:0]         cnt_total,
    output logic                     streak_hit
);
    localparam int HW = $clog2(W+1);
    localparam int RW = $clog2(STREAK_LEN+1);
    localparam logic signed [W:0] DIST_V = (W+1)'(DIST);
    localparam logic signed [W:0] ONE_V  = (W+1)'(1);
    localparam logic [RW-1:0]     LEN_V  = RW'(STREAK_LEN);

    typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    logic                valid1_q, valid1_d;
    logic [W-1:0]        xor1_q, xor1_d;
    logic signed [W:0]   dab1_q, dab1_d, dba1_q, dba1_d;
    logic                out_valid_q, out_valid_d;
    logic                gray_q, gray_d, dist_q, dist_d, more_q, more_d, less_q, less_d, none_q, none_d;
    logic [HW-1:0]       ham_q, ham_d, ham_c;
    logic                gray_c, dist_c, more_c, less_c, none_c;
    logic [CNT_W-1:0]    cg_q, cg_d, cd_q, cd_d, cm_q, cm_d, cl_q, cl_d, cn_q, cn_d, ct_q, ct_d;
    state_t              state_q, state_d;
    logic [RW-1:0]       run_q, run_d;
    logic                streak_q, streak_d;

    // Differences kept one bit wider than the operands so a-b never wraps.
    always_comb begin
        valid1_d = in_valid;
        xor1_d   = xor1_q;
        dab1_d   = dab1_q;
        dba1_d   = dba1_q;
        if (in_valid) begin
            xor1_d = a ^ b;
            dab1_d = $signed({1'b0, a}) - $signed({1'b0, b});
            dba1_d = $signed({1'b0, b}) - $signed({1'b0, a});
        end
    end

    always_comb begin
        ham_c = '0;
        for (int i = 0; i < W; i++) ham_c = ham_c + HW'(xor1_q[i]);
        gray_c = (ham_c == HW'(1));
        more_c = (dab1_q == ONE_V);
        less_c = (dba1_q == ONE_V);
        dist_c = (dab1_q == DIST_V) || (dba1_q == DIST_V);
        none_c = ~(gray_c | dist_c | more_c | less_c);
    end

    always_comb begin
        out_valid_d = valid1_q;
        gray_d = gray_q;  dist_d = dist_q;  more_d = more_q;
        less_d = less_q;  none_d = none_q;  ham_d  = ham_q;
        if (valid1_q) begin
            gray_d = gray_c;  dist_d = dist_c;  more_d = more_c;
            less_d = less_c;  none_d = none_c;  ham_d  = ham_c;
        end
        cg_d = sat_inc(cg_q, valid1_q & gray_c);
        cd_d = sat_inc(cd_q, valid1_q & dist_c);
        cm_d = sat_inc(cm_q, valid1_q & more_c);
        cl_d = sat_inc(cl_q, valid1_q & less_c);
        cn_d = sat_inc(cn_q, valid1_q & none_c);
        ct_d = sat_inc(ct_q, valid1_q);
        if (clr_cnt) begin
            cg_d = '0; cd_d = '0; cm_d = '0; cl_d = '0; cn_d = '0; ct_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (valid1_q) begin
            case (state_q)
                IDLE: if (gray_c) begin
                    state_d = RUN;
                    run_d   = RW'(1);
                end
                RUN: if (gray_c) begin
                    run_d = run_q + RW'(1);
                    if (run_q + RW'(1) == LEN_V) state_d = HIT;
                end else begin
                    state_d = IDLE;
                    run_d   = '0;
                end
                HIT: if (!gray_c) begin
                    state_d = IDLE;
                    run_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
        // Held through the cycle that shows the streak-breaking sample, dropped one cycle later.
        streak_d = (state_d == HIT) || (state_q == HIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid1_q <= 1'b0; xor1_q <= '0; dab1_q <= '0; dba1_q <= '0;
            out_valid_q <= 1'b0; gray_q <= 1'b0; dist_q <= 1'b0; more_q <= 1'b0;
            less_q <= 1'b0; none_q <= 1'b0; ham_q <= '0;
            cg_q <= '0; cd_q <= '0; cm_q <= '0; cl_q <= '0; cn_q <= '0; ct_q <= '0;
            state_q <= IDLE; run_q <= '0; streak_q <= 1'b0;
        end else begin
            valid1_q <= valid1_d; xor1_q <= xor1_d; dab1_q <= dab1_d; dba1_q <= dba1_d;
            out_valid_q <= out_valid_d; gray_q <= gray_d; dist_q <= dist_d; more_q <= more_d;
            less_q <= less_d; none_q <= none_d; ham_q <= ham_d;
            cg_q <= cg_d; cd_q <= cd_d; cm_q <= cm_d; cl_q <= cl_d; cn_q <= cn_d; ct_q <= ct_d;
            state_q <= state_d; run_q <= run_d; streak_q <= streak_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign gray        = gray_q;
    assign dist_k      = dist_q;
    assign more        = more_q;
    assign less        = less_q;
    assign no_relation = none_q;
    assign hamming     = ham_q;
    assign cnt_gray    = cg_q;
    assign cnt_dist    = cd_q;
    assign cnt_more    = cm_q;
    assign cnt_less    = cl_q;
    assign cnt_none    = cn_q;
    assign cnt_total   = ct_q;
    assign streak_hit  = streak_q;
endmodule

// File: doc/relation_detector_pipe.md
Name: relation_detector_pipe

Overview:
- Pipelined, parametrised successor to the lab-3 combinational A/B relation detector.
- Classifies each valid pair (a, b) of W-bit unsigned operands into relation flags:
  - gray: Hamming distance exactly 1
  - dist_k: |a-b| == DIST
  - more: a == b+1
  - less: b == a+1
  - no_relation: none of the above
- Also keeps per-class saturating event counters and a gray-streak detector FSM.
- Sits between a stimulus/capture stream source and the lab status/display logic.

Parameters:
- W, 3, operand width in bits (W >= 2).
- DIST, 3, absolute-difference value flagged by dist_k (1 <= DIST <= 2**W-1).
- CNT_W, 8, width of every event counter.
- STREAK_LEN, 4, number of consecutive gray samples that raises streak_hit (>= 2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  a/b valid this cycle.
- a  in  W  operand A, unsigned.
- b  in  W  operand B, unsigned.
- clr_cnt  in  1  synchronous clear of all counters.
- out_valid  out  1  flags correspond to a sample.
- gray  out  1  Hamming(a,b) == 1.
- dist_k  out  1  |a-b| == DIST.
- more  out  1  a-b == 1.
- less  out  1  b-a == 1.
- no_relation  out  1  ~(gray|dist_k|more|less).
- hamming  out  $clog2(W+1)  popcount(a^b).
- cnt_gray, cnt_dist, cnt_more, cnt_less, cnt_none, cnt_total  out  CNT_W each  event counters.
- streak_hit  out  1  STREAK_LEN or more consecutive gray samples.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is synchronous and active-low: rst_n is sampled on the rising edge of clk.
  - While rst_n=0 at an edge, all outputs, pipeline registers and counters go to 0, and the FSM goes to IDLE.
  - Reset mid-stream discards in-flight samples.
- Pipeline, latency 2:
  - Stage 1 (edge N, in_valid=1): registers a^b, a-b and b-a as W+1-bit signed differences, plus a valid bit.
  - Stage 2 (edge N+1): registers the flags and hamming, and sets out_valid.
  - out_valid is high for exactly one cycle per accepted sample.
  - Back-to-back samples are accepted every cycle; no backpressure.
- Flag values when out_valid=0:
  - gray, dist_k, more, less, no_relation and hamming hold their previous values.
  - Consumers qualify them with out_valid.
- Arithmetic:
  - Differences are computed at full width with no modular wrap: a=0, b=2**W-1 is NOT more.
  - Flags are not mutually exclusive. Example: a=1, b=0 gives gray=1 and more=1.
  - If DIST==1, dist_k equals more|less.
  - no_relation is a pure function of the other four flags of the same sample; it never latches.
- Counters:
  - Updated on the edge that loads stage 2, so counter values include the sample displayed in the same cycle.
  - cnt_total increments per valid sample.
  - Each class counter increments when its flag is set. cnt_none tracks no_relation.
  - Counters saturate at 2**CNT_W-1; no wrap.
  - clr_cnt=1 at an edge zeroes all counters. Clear wins over a simultaneous increment, and that sample is not counted.
  - clr_cnt does not affect flags or the FSM.
- Streak FSM:
  - Advances only on stage-2 valid samples; bubbles (out_valid=0) hold state and run count.
  - IDLE: gray sample -> RUN with run=1; non-gray sample -> stay IDLE.
  - RUN: gray sample -> run+1, then go to HIT when run+1 == STREAK_LEN; non-gray sample -> IDLE with run=0.
  - HIT: gray sample -> stay HIT; non-gray sample -> IDLE with run=0.
- streak_hit:
  - Registered; equals (state==HIT).
  - Rises in the same cycle that out_valid shows the STREAK_LEN-th consecutive gray sample.
  - Falls in the cycle after the out_valid that shows a non-gray sample.

Test Plan:
1. Reset, then a=1,b=0 at edge 0 -> at cycle 2: out_valid=1, gray=1, more=1, less=0, dist_k=0, no_relation=0, hamming=1, cnt_total=1, cnt_gray=1, cnt_more=1.
2. Default W=3: a=5,b=2 -> dist_k=1, hamming=3, no_relation=0. Then a=0,b=7 -> more=0, less=0, dist_k=0, hamming=3, no_relation=1, cnt_none=1.
3. Exhaustive W=3: all 64 pairs streamed back-to-back -> each flag matches the reference model, out_valid high for 64 consecutive cycles, cnt_total=64.
4. Streak: gray pairs (0,1),(3,2),(6,7),(4,5) with a bubble inserted between pairs 2 and 3, then non-gray (0,3):
   - streak_hit rises with the 4th out_valid.
   - It falls in the cycle after out_valid for (0,3).
5. Saturation and clear, CNT_W=4:
   - 20 gray samples -> cnt_gray=15, cnt_total=15.
   - clr_cnt asserted on the same edge as a gray sample -> all counters 0.
   - The next gray sample gives cnt_gray=1.
6. Reset mid-stream: rst_n=0 for one edge while 2 samples are in flight:
   - out_valid stays 0 for those samples.
   - Counters and streak_hit are 0.
   - A fresh sample after reset appears 2 cycles later.
